// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring phase monitor.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int RING_WIDTH = 6;
    localparam logic [RING_WIDTH-1:0] RING_PHASE0 = RING_WIDTH'(1);

    // The ring advances by a right rotate: bit 0 wraps into the MSB.
    function automatic logic [RING_WIDTH-1:0] ring_rotate_right(input logic [RING_WIDTH-1:0] x);
        return {x[0], x[RING_WIDTH-1:1]};
    endfunction

    function automatic logic [2:0] ring_onehot_to_index(input logic [RING_WIDTH-1:0] x);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < RING_WIDTH; i++) begin
            if (x[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
module onehot_encoder #(
    parameter int WIDTH = 6,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
        is_onehot = $onehot(onehot);
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Locks onto a right-rotating one-hot ring, reports phase index, revolutions and faults.
// Optional: RING_PHASE_MONITOR_AUTO_RESYNC_EN lets FAULT fall back to SYNC once phase 0 reappears.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH,
    parameter int REV_W = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] phase_in,
    output logic [IDX_W-1:0] phase_idx,
    output logic             phase_valid,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_pulse,
    output logic             fault,
    output logic             resync_req
);

    localparam logic [WIDTH-1:0] PHASE_ZERO = WIDTH'(1);

    function automatic logic [WIDTH-1:0] rotate_next(input logic [WIDTH-1:0] x);
        return {x[0], x[WIDTH-1:1]};
    endfunction

    state_t           state;
    logic [WIDTH-1:0] expected;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_onehot;
    logic             in_seq;
    logic             at_phase0;

    onehot_encoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .onehot    (phase_in),
        .idx       (enc_idx),
        .is_onehot (enc_onehot)
    );

    assign at_phase0 = (phase_in == PHASE_ZERO);
    // Equality with a one-hot expected value already implies one-hot; the flag guards expected==0.
    assign in_seq    = enc_onehot && (phase_in == expected);

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            expected    <= '0;
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            rev_count   <= '0;
            rev_pulse   <= 1'b0;
            fault       <= 1'b0;
            resync_req  <= 1'b0;
        end else begin
            rev_pulse <= 1'b0;
            if (!enable) begin
                state       <= IDLE;
                phase_valid <= 1'b0;
                resync_req  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SYNC;
                        fault <= 1'b0;
                    end
                    SYNC: begin
                        if (at_phase0) begin
                            state       <= TRACK;
                            phase_idx   <= '0;
                            phase_valid <= 1'b1;
                            expected    <= rotate_next(phase_in);
                        end else begin
                            phase_valid <= 1'b0;
                        end
                    end
                    TRACK: begin
                        if (in_seq) begin
                            phase_idx   <= enc_idx;
                            phase_valid <= 1'b1;
                            expected    <= rotate_next(phase_in);
                            // Only a matched phase 0 inside TRACK closes a revolution.
                            if (at_phase0) begin
                                rev_count <= rev_count + REV_W'(1);
                                rev_pulse <= 1'b1;
                            end
                        end else begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            resync_req  <= 1'b1;
                            phase_valid <= 1'b0;
                        end
                    end
                    FAULT: begin
`ifdef RING_PHASE_MONITOR_AUTO_RESYNC_EN
                        if (at_phase0) begin
                            state      <= SYNC;
                            resync_req <= 1'b0;
                        end else begin
                            resync_req <= 1'b1;
                        end
`else
                        resync_req <= 1'b1;
`endif
                        fault       <= 1'b1;
                        phase_valid <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor (REV_W=8 and REV_W=2 instances on shared stimulus).
module tb_ring_phase_monitor;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       enable = 1'b0;
    logic [5:0] phase_in = '0;

    logic [2:0] phase_idx, s_phase_idx;
    logic       phase_valid, s_phase_valid;
    logic [7:0] rev_count;
    logic [1:0] s_rev_count;
    logic       rev_pulse, s_rev_pulse;
    logic       fault, s_fault;
    logic       resync_req, s_resync_req;

    typedef struct {
        int idx;
        int valid;
        int rev;
        int pulse;
        int flt;
        int resync;
        int step;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    ring_phase_monitor #(.WIDTH(6), .REV_W(8), .IDX_W(3)) dut (
        .clk         (clk),
        .clear       (clear),
        .enable      (enable),
        .phase_in    (phase_in),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .rev_count   (rev_count),
        .rev_pulse   (rev_pulse),
        .fault       (fault),
        .resync_req  (resync_req)
    );

    ring_phase_monitor #(.WIDTH(6), .REV_W(2), .IDX_W(3)) dut_small (
        .clk         (clk),
        .clear       (clear),
        .enable      (enable),
        .phase_in    (phase_in),
        .phase_idx   (s_phase_idx),
        .phase_valid (s_phase_valid),
        .rev_count   (s_rev_count),
        .rev_pulse   (s_rev_pulse),
        .fault       (s_fault),
        .resync_req  (s_resync_req)
    );

    task automatic chk(input string name, input int step, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp_v);
        end
    endtask

    task automatic drive(input logic clr, input logic en, input logic [5:0] ph,
                         input int e_idx, input int e_val, input int e_rev,
                         input int e_pulse, input int e_flt, input int e_rsy);
        exp_t e;
        @(negedge clk);
        clear    = clr;
        enable   = en;
        phase_in = ph;
        e.idx = e_idx; e.valid = e_val; e.rev = e_rev; e.pulse = e_pulse;
        e.flt = e_flt; e.resync = e_rsy; e.step = step_no;
        step_no++;
        sb.push_back(e);
    endtask

    // Monitor: outputs settle after each rising edge; check one queued expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("phase_idx",   e.step, int'(phase_idx),   e.idx);
                chk("phase_valid", e.step, int'(phase_valid), e.valid);
                chk("rev_count",   e.step, int'(rev_count),   e.rev);
                chk("rev_pulse",   e.step, int'(rev_pulse),   e.pulse);
                chk("fault",       e.step, int'(fault),       e.flt);
                chk("resync_req",  e.step, int'(resync_req),  e.resync);
                chk("small_rev_count", e.step, int'(s_rev_count), e.rev % 4);
                chk("small_rev_pulse", e.step, int'(s_rev_pulse), e.pulse);
                chk("small_phase_idx", e.step, int'(s_phase_idx), e.idx);
            end
        end
    end

    initial begin
        logic [5:0] ph;
        int         guard;

        drive(1'b1, 1'b0, 6'b000000, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 6'b000000, 0, 0, 0, 0, 0, 0);
        // IDLE -> SYNC: outputs hold even though phase 0 is present.
        drive(1'b0, 1'b1, 6'b000001, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b000001, 0, 1, 0, 0, 0, 0);

        // Five clean revolutions: indices 5,4,3,2,1 then 0 with a pulse.
        for (int r = 1; r <= 5; r++) begin
            ph = 6'b100000;
            for (int k = 5; k >= 1; k--) begin
                drive(1'b0, 1'b1, ph, k, 1, r - 1, 0, 0, 0);
                ph = {ph[0], ph[5:1]};
            end
            drive(1'b0, 1'b1, 6'b000001, 0, 1, r, 1, 0, 0);
        end

        drive(1'b0, 1'b1, 6'b100000, 5, 1, 5, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b010000, 4, 1, 5, 0, 0, 0);
        // Multi-hot injection: fault, index holds at 4.
        drive(1'b0, 1'b1, 6'b010100, 4, 0, 5, 0, 1, 1);
`ifdef RING_PHASE_MONITOR_AUTO_RESYNC_EN
        drive(1'b0, 1'b1, 6'b000001, 4, 0, 5, 0, 1, 0);
`else
        drive(1'b0, 1'b1, 6'b000001, 4, 0, 5, 0, 1, 1);
`endif
        // enable low: IDLE, fault and rev_count retained, resync dropped.
        drive(1'b0, 1'b0, 6'b100000, 4, 0, 5, 0, 1, 0);
        // IDLE -> SYNC clears fault.
        drive(1'b0, 1'b1, 6'b000100, 4, 0, 5, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b000100, 4, 0, 5, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b000001, 0, 1, 5, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b100000, 5, 1, 5, 0, 0, 0);
        // Ring cleared to all-zero: fault, stays in FAULT.
        drive(1'b0, 1'b1, 6'b000000, 5, 0, 5, 0, 1, 1);
        drive(1'b0, 1'b1, 6'b000000, 5, 0, 5, 0, 1, 1);
        // clear wins over enable and a bad phase.
        drive(1'b1, 1'b1, 6'b011000, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b000010, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 6'b000001, 0, 1, 0, 0, 0, 0);
        // Stall on phase 0: fault, index holds at 0.
        drive(1'b0, 1'b1, 6'b000001, 0, 0, 0, 0, 1, 1);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #5;
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
